ebus_diag_reader: RTL and testbench
===================================

// Module: ebus_diag_reader
// PURPOSE
// - EBUS-side initiator for EDP diagnostic reads. Accepts a register-select request, drives
//   DIAG_FUNC / diagReadFunc12X, waits for the EDP to drive EBUS, captures the 36-bit word.
// - Returns the word on a valid/ready response port. Sits between the console/diag logic and
//   the EDP in ebox.v. A scan mode reads all eight EDP groups back to back.
// PARAMETERS
// - SETTLE_CYCLES  2   cycles EBUS must be driven before capture (1..7)
// - TIMEOUT        15  max cycles in DRIVE waiting for EDPdrivingEBUS (1..63)
// PORTS
// - eboxClk          in   1     sole clock; all state on posedge
// - eboxReset        in   1     synchronous, active-high reset
// - reqValid         in   1     request present
// - reqReady         out  1     request accepted when reqValid & reqReady
// - reqSel           in   [0:2] group: 0 AR,1 BR,2 MQ,3 FM,4 BRX,5 ARX,6 ADX,7 AD
// - reqScan          in   1     1 = read groups 0..7 in order, reqSel ignored
// - rspValid         out  1     response word held stable until rspReady
// - rspReady         in   1     response consumed when rspValid & rspReady
// - rspSel           out  [0:2] group the response belongs to
// - rspData          out  [0:35] captured EBUS word
// - rspTimeout       out  1     1 = EDP never drove EBUS; rspData forced 0
// - rspLast          out  1     last response of a request (always 1 if not scan)
// - DIAG_FUNC        out  [0:8] {4'b0101, sel[0:2], 2'b00}; 0 when not in DRIVE/CAPTURE
// - diagReadFunc12X  out  1     high in DRIVE and CAPTURE only
// - EBUS             in   [0:35] shared EBUS data
// - EDPdrivingEBUS   in   1     EDP acknowledges it is driving EBUS
// BEHAVIOUR
// - Reset: state IDLE; reqReady=1; rspValid, rspTimeout, rspLast, diagReadFunc12X=0;
//   DIAG_FUNC, rspSel, rspData=0; counters 0. Reset mid-operation aborts immediately,
//   any pending response is dropped, no partial output next cycle.
// - IDLE: reqReady=1. On accept latch sel (0 if reqScan) and scan flag -> DRIVE.
//   reqReady=0 in every other state; no queueing of a second request.
// - DRIVE: DIAG_FUNC/diagReadFunc12X driven from the cycle after accept. settle counter
//   counts cycles with EDPdrivingEBUS=1 (clears if it drops). settle==SETTLE_CYCLES ->
//   CAPTURE. wait counter counts every DRIVE cycle; reaching TIMEOUT before settle done ->
//   RESP with rspTimeout=1, rspData=0.
// - CAPTURE: one cycle; rspData <= EBUS, rspTimeout<=0 -> RESP. Function held this cycle.
// - RESP: function outputs 0, rspValid=1, rspSel=current sel, rspLast=(!scan | sel==7).
//   Outputs stable while rspReady=0. On handshake: if scan and sel!=7, sel+1 -> DRIVE;
//   else -> IDLE (reqReady=1 the following cycle).
// - Min latency accept->rspValid: 1 + SETTLE_CYCLES + 1 cycles with EDPdrivingEBUS
//   already high (4 with defaults). Timeout latency: TIMEOUT+1.
// - sel increment is 3-bit; scan terminates at 7, never wraps to 0.
// - Timeout within scan does not abort scan; following groups still read.
// - reqValid high during busy is ignored (not latched); requester must hold it.
// CONFIGURATION
// - EBUS_DIAG_PARITY_EN defined: adds out port rspParity (1) = odd parity of rspData
//   (~^rspData registered with rspData; 1 on reset and on timeout since data 0), and
//   the captured word is also checked: rspData stable across RESP asserted by an
//   internal assertion. Undefined: port absent, no parity logic.
// TESTING
// - reqSel=5, EDPdrivingEBUS=1 always, EBUS=36'o123456_701234 -> DIAG_FUNC=9'b0101_101_00,
//   rspValid on 4th cycle after accept, rspData=36'o123456701234, rspSel=5, rspLast=1.
// - EDPdrivingEBUS=0 throughout, reqSel=2 -> rspValid at cycle 16, rspTimeout=1, rspData=0.
// - reqScan=1, EBUS=sel*36'o010101_010101 -> 8 responses sel 0..7, rspLast only on sel 7,
//   then IDLE, reqReady=1.
// - rspReady held 0 for 10 cycles in RESP -> rspData/rspSel unchanged, DIAG_FUNC=0.
// - EDPdrivingEBUS toggles 1,0,1,1 -> capture only after 2 consecutive high cycles.
// - eboxReset pulsed in DRIVE during scan sel=3 -> next cycle all outputs reset values,
//   reqReady=1; with EBUS_DIAG_PARITY_EN, rspParity=1 after reset and matches ~^rspData.

Source files
------------

// File: rtl/ebus_diag_reader_if.sv
// Request/response handshake plus EBUS diagnostic bus of the EDP diagnostic reader.
// Optional rspParity exists only when EBUS_DIAG_PARITY_EN is defined.
interface ebus_diag_reader_if;
    logic        reqValid;
    logic        reqReady;
    logic [0:2]  reqSel;
    logic        reqScan;
    logic        rspValid;
    logic        rspReady;
    logic [0:2]  rspSel;
    logic [0:35] rspData;
    logic        rspTimeout;
    logic        rspLast;
    logic [0:8]  DIAG_FUNC;
    logic        diagReadFunc12X;
    logic [0:35] EBUS;
    logic        EDPdrivingEBUS;
`ifdef EBUS_DIAG_PARITY_EN
    logic        rspParity;
`endif

    // master: requester/EDP side; slave: the reader itself
    modport master (
        output reqValid, reqSel, reqScan, rspReady, EBUS, EDPdrivingEBUS,
        input  reqReady, rspValid, rspSel, rspData, rspTimeout, rspLast,
`ifdef EBUS_DIAG_PARITY_EN
        input  rspParity,
`endif
        input  DIAG_FUNC, diagReadFunc12X
    );

    modport slave (
        input  reqValid, reqSel, reqScan, rspReady, EBUS, EDPdrivingEBUS,
        output reqReady, rspValid, rspSel, rspData, rspTimeout, rspLast,
`ifdef EBUS_DIAG_PARITY_EN
        output rspParity,
`endif
        output DIAG_FUNC, diagReadFunc12X
    );
endinterface

// File: rtl/ebus_diag_reader.sv
// EBUS-side initiator for EDP diagnostic reads, single group or full 8-group scan.
// Optional macro EBUS_DIAG_PARITY_EN adds rspParity and a stability assertion on rspData.
module ebus_diag_reader #(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 15
) (
    input  logic              eboxClk,
    input  logic              eboxReset,
    ebus_diag_reader_if.slave bus,
    output logic [1:0]        dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid and its payload hold stable until that edge, ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [2:0] SETTLE_MAX = 3'(SETTLE_CYCLES);
    localparam logic [5:0] WAIT_MAX   = 6'(TIMEOUT);
    localparam logic [3:0] READ_OP    = 4'b0101;

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic        scan_q, scan_d;
    logic [2:0]  settle_q, settle_d;
    logic [5:0]  wait_q, wait_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [2:0]  rsp_sel_q, rsp_sel_d;
    logic [0:35] rsp_data_q, rsp_data_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        rsp_last_q, rsp_last_d;
    logic [0:8]  diag_func_q, diag_func_d;
    logic        diag_read_q, diag_read_d;
`ifdef EBUS_DIAG_PARITY_EN
    logic        rsp_parity_q, rsp_parity_d;
`endif

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        scan_d        = scan_q;
        settle_d      = settle_q;
        wait_d        = wait_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_sel_d     = rsp_sel_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_last_d    = rsp_last_q;
        diag_func_d   = diag_func_q;
        diag_read_d   = diag_read_q;
        case (state_q)
            IDLE: begin
                if (bus.reqValid && req_ready_q) begin
                    sel_d       = bus.reqScan ? 3'd0 : bus.reqSel;
                    scan_d      = bus.reqScan;
                    settle_d    = 3'd0;
                    wait_d      = 6'd0;
                    req_ready_d = 1'b0;
                    diag_func_d = {READ_OP, sel_d, 2'b00};
                    diag_read_d = 1'b1;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_MAX) begin
                    state_d = CAPTURE;
                end else if (wait_q == WAIT_MAX) begin
                    diag_func_d   = '0;
                    diag_read_d   = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_sel_d     = sel_q;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_last_d    = !scan_q || (sel_q == 3'd7);
                    state_d       = RESP;
                end else begin
                    // only an unbroken run of EDP acknowledges counts towards settling
                    settle_d = bus.EDPdrivingEBUS ? settle_q + 3'd1 : 3'd0;
                    wait_d   = wait_q + 6'd1;
                end
            end
            CAPTURE: begin
                diag_func_d   = '0;
                diag_read_d   = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_sel_d     = sel_q;
                rsp_data_d    = bus.EBUS;
                rsp_timeout_d = 1'b0;
                rsp_last_d    = !scan_q || (sel_q == 3'd7);
                state_d       = RESP;
            end
            RESP: begin
                if (bus.rspReady) begin
                    rsp_valid_d = 1'b0;
                    if (scan_q && (sel_q != 3'd7)) begin
                        sel_d       = sel_q + 3'd1;
                        settle_d    = 3'd0;
                        wait_d      = 6'd0;
                        diag_func_d = {READ_OP, sel_d, 2'b00};
                        diag_read_d = 1'b1;
                        state_d     = DRIVE;
                    end else begin
                        req_ready_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef EBUS_DIAG_PARITY_EN
        rsp_parity_d = ~^rsp_data_d;
`endif
    end

    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            state_q       <= IDLE;
            sel_q         <= 3'd0;
            scan_q        <= 1'b0;
            settle_q      <= 3'd0;
            wait_q        <= 6'd0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_sel_q     <= 3'd0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_last_q    <= 1'b0;
            diag_func_q   <= '0;
            diag_read_q   <= 1'b0;
`ifdef EBUS_DIAG_PARITY_EN
            rsp_parity_q  <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            scan_q        <= scan_d;
            settle_q      <= settle_d;
            wait_q        <= wait_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_sel_q     <= rsp_sel_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_last_q    <= rsp_last_d;
            diag_func_q   <= diag_func_d;
            diag_read_q   <= diag_read_d;
`ifdef EBUS_DIAG_PARITY_EN
            rsp_parity_q  <= rsp_parity_d;
`endif
        end
    end

`ifdef EBUS_DIAG_PARITY_EN
    assign bus.rspParity = rsp_parity_q;

    a_rsp_data_stable: assert property (@(posedge eboxClk) disable iff (eboxReset)
        (rsp_valid_q && !bus.rspReady) |=> $stable(rsp_data_q));
`endif

    assign bus.reqReady        = req_ready_q;
    assign bus.rspValid        = rsp_valid_q;
    assign bus.rspSel          = rsp_sel_q;
    assign bus.rspData         = rsp_data_q;
    assign bus.rspTimeout      = rsp_timeout_q;
    assign bus.rspLast         = rsp_last_q;
    assign bus.DIAG_FUNC       = diag_func_q;
    assign bus.diagReadFunc12X = diag_read_q;
    assign dbg_state           = state_q;
endmodule

// File: tb/tb_ebus_diag_reader.sv
// Directed bench for ebus_diag_reader: driver tasks push expected responses, a monitor
// pops and compares on every response handshake.
module tb_ebus_diag_reader;
    localparam logic [35:0] SCAN_K = 36'o010101010101;

    logic        clk;
    logic        rst;
    logic [1:0]  dbg_state;
    logic        ebus_mode;
    logic [35:0] ebus_fixed;
    int          checks;
    int          errors;
    int          cyc;

    // {timeout, last, sel[2:0], data[35:0]}
    logic [40:0] exp_q[$];

    ebus_diag_reader_if bus ();

    ebus_diag_reader dut (
        .eboxClk   (clk),
        .eboxReset (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // EDP model: in scan mode the EDP returns sel * SCAN_K for the group being read
    always_comb begin
        logic [35:0] sel_ext;
        sel_ext = {33'd0, bus.DIAG_FUNC[4:6]};
        bus.EBUS = ebus_mode ? (sel_ext * SCAN_K) : ebus_fixed;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [40:0] mk_exp(input logic to, input logic last,
                                           input logic [2:0] sel, input logic [35:0] data);
        return {to, last, sel, data};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.rspValid && bus.rspReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {23'd0, bus.rspTimeout, bus.rspLast, bus.rspSel, bus.rspData}, 64'h1_dead_beef);
            end else begin
                logic [40:0] e;
                e = exp_q.pop_front();
                check("rsp", {23'd0, bus.rspTimeout, bus.rspLast, bus.rspSel, bus.rspData}, {23'd0, e});
`ifdef EBUS_DIAG_PARITY_EN
                check("rsp_parity", {63'd0, bus.rspParity}, {63'd0, ~^e[35:0]});
`endif
            end
        end
    end

    // driver tasks
    task automatic send_req(input logic [2:0] sel, input logic scan);
        bus.reqValid = 1'b1;
        bus.reqSel   = sel;
        bus.reqScan  = scan;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.reqReady) break;
        end
        if (!bus.reqReady) check("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.reqValid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.rspValid && n < 100) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(bus.reqReady && exp_q.size() == 0) && n < limit) begin
            tick(1);
            n++;
        end
        if (n >= limit) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reqReady"}, {63'd0, bus.reqReady}, 64'd1);
        check({tag, "_rspValid"}, {63'd0, bus.rspValid}, 64'd0);
        check({tag, "_rspTimeout"}, {63'd0, bus.rspTimeout}, 64'd0);
        check({tag, "_rspLast"}, {63'd0, bus.rspLast}, 64'd0);
        check({tag, "_diagRead"}, {63'd0, bus.diagReadFunc12X}, 64'd0);
        check({tag, "_DIAG_FUNC"}, {55'd0, bus.DIAG_FUNC}, 64'd0);
        check({tag, "_rspSel"}, {61'd0, bus.rspSel}, 64'd0);
        check({tag, "_rspData"}, {28'd0, bus.rspData}, 64'd0);
        check({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
`ifdef EBUS_DIAG_PARITY_EN
        check({tag, "_rspParity"}, {63'd0, bus.rspParity}, 64'd1);
        check({tag, "_parity_vs_data"}, {63'd0, bus.rspParity}, {63'd0, ~^bus.rspData});
`endif
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        cyc = 0;
        rst = 1'b1;
        ebus_mode = 1'b0;
        ebus_fixed = '0;
        bus.reqValid = 1'b0;
        bus.reqSel = 3'd0;
        bus.reqScan = 1'b0;
        bus.rspReady = 1'b1;
        bus.EDPdrivingEBUS = 1'b0;
        tick(3);
        rst = 1'b0;
        check_reset_outputs("reset");

        // single read of group 5 with EDP already driving
        bus.EDPdrivingEBUS = 1'b1;
        ebus_fixed = 36'o123456701234;
        exp_q.push_back(mk_exp(1'b0, 1'b1, 3'd5, 36'o123456701234));
        send_req(3'd5, 1'b0);
        check("drive_DIAG_FUNC", {55'd0, bus.DIAG_FUNC}, {55'd0, 9'b0101_101_00});
        check("drive_diagRead", {63'd0, bus.diagReadFunc12X}, 64'd1);
        check("busy_reqReady", {63'd0, bus.reqReady}, 64'd0);
        wait_valid(lat);
        check("latency_normal", 64'(lat), 64'd4);
        wait_idle(50);

        // EDP never answers: timeout on group 2
        bus.EDPdrivingEBUS = 1'b0;
        ebus_fixed = 36'o777777777777;
        exp_q.push_back(mk_exp(1'b1, 1'b1, 3'd2, 36'd0));
        send_req(3'd2, 1'b0);
        check("to_DIAG_FUNC", {55'd0, bus.DIAG_FUNC}, {55'd0, 9'b0101_010_00});
        wait_valid(lat);
        check("latency_timeout", 64'(lat), 64'd16);
        wait_idle(50);

        // full scan, reqSel ignored
        bus.EDPdrivingEBUS = 1'b1;
        ebus_mode = 1'b1;
        for (int s = 0; s < 8; s++)
            exp_q.push_back(mk_exp(1'b0, s == 7, 3'(s), 36'(s) * SCAN_K));
        send_req(3'd4, 1'b1);
        wait_idle(300);
        check("scan_end_reqReady", {63'd0, bus.reqReady}, 64'd1);
        check("scan_end_state", {62'd0, dbg_state}, 64'd0);
        check("scan_end_rspLast", {63'd0, bus.rspLast}, 64'd1);
        ebus_mode = 1'b0;

        // back-pressure: hold response 10 cycles while EBUS changes underneath
        bus.rspReady = 1'b0;
        ebus_fixed = 36'o700000111222;
        exp_q.push_back(mk_exp(1'b0, 1'b1, 3'd6, 36'o700000111222));
        send_req(3'd6, 1'b0);
        wait_valid(lat);
        check("latency_hold", 64'(lat), 64'd4);
        ebus_fixed = 36'o000000000077;
        for (int i = 0; i < 10; i++) begin
            check("hold_rspValid", {63'd0, bus.rspValid}, 64'd1);
            check("hold_rspData", {28'd0, bus.rspData}, {28'd0, 36'o700000111222});
            check("hold_rspSel", {61'd0, bus.rspSel}, 64'd6);
            check("hold_DIAG_FUNC", {55'd0, bus.DIAG_FUNC}, 64'd0);
            check("hold_diagRead", {63'd0, bus.diagReadFunc12X}, 64'd0);
            tick(1);
        end
        bus.rspReady = 1'b1;
        wait_idle(50);

        // EDP acknowledge 1,0,1,1: settle restarts after the drop
        bus.EDPdrivingEBUS = 1'b0;
        ebus_fixed = 36'o135713571357;
        exp_q.push_back(mk_exp(1'b0, 1'b1, 3'd1, 36'o135713571357));
        send_req(3'd1, 1'b0);
        bus.EDPdrivingEBUS = 1'b1;
        tick(1);
        bus.EDPdrivingEBUS = 1'b0;
        tick(1);
        bus.EDPdrivingEBUS = 1'b1;
        tick(2);
        check("toggle_still_drive", {62'd0, dbg_state}, 64'd1);
        tick(1);
        check("toggle_capture", {62'd0, dbg_state}, 64'd2);
        check("toggle_no_valid_yet", {63'd0, bus.rspValid}, 64'd0);
        tick(1);
        check("toggle_rspValid", {63'd0, bus.rspValid}, 64'd1);
        wait_idle(50);

        // reset pulse while scan is driving group 3
        ebus_mode = 1'b1;
        for (int s = 0; s < 3; s++)
            exp_q.push_back(mk_exp(1'b0, 1'b0, 3'(s), 36'(s) * SCAN_K));
        send_req(3'd0, 1'b1);
        lat = 0;
        while (!(dbg_state == 2'd1 && bus.DIAG_FUNC[4:6] == 3'd3) && lat < 200) begin
            tick(1);
            lat++;
        end
        check("scan_reach_sel3", {55'd0, bus.DIAG_FUNC}, {55'd0, 9'b0101_011_00});
        check("scan_pre_reset_consumed", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_outputs("midreset");
        tick(3);
        check("post_reset_quiet", {63'd0, bus.rspValid}, 64'd0);

        // normal read of group 7 after the aborted scan
        ebus_mode = 1'b0;
        ebus_fixed = 36'o246024602460;
        exp_q.push_back(mk_exp(1'b0, 1'b1, 3'd7, 36'o246024602460));
        send_req(3'd7, 1'b0);
        wait_valid(lat);
        check("latency_after_reset", 64'(lat), 64'd4);
        wait_idle(50);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
